// File: rtl/ddr2_mgr_pkg.sv
// Shared definitions for the DDR2 manager clients: bus widths, the write-client
// state encoding and the word-to-column address helper.
package ddr2_mgr_pkg;

  localparam int MEM_ADDR_W = 25;
  localparam int MEM_DATA_W = 32;
  localparam int XFR_LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    NEXT = 2'd3
  } wr_state_t;

  // One 32-bit word spans two 16-bit memory columns.
  function automatic logic [MEM_ADDR_W-1:0] words_to_cols(input logic [XFR_LEN_W-1:0] words);
    return {{(MEM_ADDR_W-XFR_LEN_W-1){1'b0}}, words, 1'b0};
  endfunction

endpackage

// File: rtl/pix_wr_buf_chk.sv
// Protocol checks for the pixel write buffer: no pull against an empty FIFO
// during a burst, and no grant unless a request is outstanding.
module pix_wr_buf_chk (
  input logic clk,
  input logic rst_n,
  input logic pop_req,
  input logic fifo_empty,
  input logic grant,
  input logic in_req
);

  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_req && fifo_empty))
    else $error("pix_wr_buf: data pull while FIFO empty");

  a_grant_in_req: assert property (@(posedge clk) disable iff (!rst_n) !(grant && !in_req))
    else $error("pix_wr_buf: grant received without pending request");

endmodule

// File: rtl/pix_wr_fifo.sv
// Synchronous first-word-fall-through FIFO. dout shows the head word and reads
// as zero while empty. Push and pop may coincide at any fill level; clr empties
// the FIFO and takes priority over both.
module pix_wr_fifo #(
  parameter  int DEPTH = 64,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? {W{1'b0}} : mem[rd_ptr];

  // Storage array; no reset needed because empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (clr) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix_wr_buf.sv
// Pixel write buffer: packs 8-bit pixels little-endian into 32-bit words, queues
// them in a FWFT FIFO and writes them to the DDR2 frame area in fixed bursts,
// wrapping back to BASE_ADDR at the end of each frame.
// Optional feature macro PIX_WR_FLUSH_EN adds a flush port that pushes out a
// short final burst (partial packer word zero-padded).
module pix_wr_buf
  import ddr2_mgr_pkg::*;
#(
  parameter int                    XFR_LEN     = 16,
  parameter int                    FIFO_DEPTH  = 64,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = 25'h0,
  parameter int                    FRAME_WORDS = 153600
) (
  input  logic                  mem_clk0,
  input  logic                  mem_rst_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [7:0]            pix_data,
  output logic                  pix_ready,
  output logic                  wr_mem_req,
  output logic [MEM_ADDR_W-1:0] wr_mem_addr,
  output logic [XFR_LEN_W-1:0]  wr_xfr_len,
  input  logic                  wr_mem_grant,
  input  logic                  wr_data_pull,
  output logic [MEM_DATA_W-1:0] wr_data,
  output logic                  frame_done
`ifdef PIX_WR_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int                  CW            = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]       XFR_LEN_C     = CW'(XFR_LEN);
  localparam logic [XFR_LEN_W-1:0] XFR_LEN_L    = XFR_LEN_W'(XFR_LEN);
  localparam logic [31:0]         FRAME_WORDS_C = 32'(FRAME_WORDS);

  wr_state_t              state;
  logic                   ready_en;
  logic [1:0]             pk_cnt;
  logic [31:0]            pk_word;
  logic [XFR_LEN_W-1:0]   xfer_cnt;
  logic [31:0]            words_written;
  logic [31:0]            ww_next;
  logic                   start_pend;
  logic                   flush_pend;
  logic                   flush_active;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pix_acc;
  logic                   start_now;
  logic                   pad_now;
  logic                   frame_wrap;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [MEM_DATA_W-1:0]  fifo_din;

`ifdef PIX_WR_FLUSH_EN
  assign flush_active = flush | flush_pend;
`else
  assign flush_active = 1'b0;
`endif

  // Datapath steering: frame restart timing, flush padding, FIFO push/pop.
  always_comb begin
    start_now = 1'b0;
    pad_now   = 1'b0;
    fifo_push = 1'b0;
    fifo_din  = pk_word;
    if (state == IDLE || state == REQ) begin
      start_now = frame_start;
    end else if (state == NEXT) begin
      start_now = frame_start | start_pend;
    end else begin
      start_now = 1'b0;
    end
    if (state == IDLE && flush_active && pk_cnt != 2'd0 && !start_now) begin
      pad_now = 1'b1;
    end else begin
      pad_now = 1'b0;
    end
    pix_ready = ready_en & ~fifo_full & ~pad_now;
    pix_acc   = pix_valid & pix_ready;
    if (pad_now) begin
      fifo_push = 1'b1;
      fifo_din  = pk_word;
    end else if (pix_acc && pk_cnt == 2'd3) begin
      fifo_push = 1'b1;
      fifo_din  = {pix_data, pk_word[23:0]};
    end else begin
      fifo_push = 1'b0;
      fifo_din  = pk_word;
    end
    fifo_pop   = (state == XFER) & wr_data_pull & ~fifo_empty;
    ww_next    = words_written + 32'(wr_xfr_len);
    frame_wrap = (ww_next >= FRAME_WORDS_C);
  end

  // Byte packer; unused upper bytes stay zero so a flushed word is padded.
  always_ff @(posedge mem_clk0 or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      ready_en <= 1'b0;
      pk_cnt   <= 2'd0;
      pk_word  <= 32'd0;
    end else begin
      ready_en <= 1'b1;
      if (start_now || pad_now) begin
        pk_cnt  <= 2'd0;
        pk_word <= 32'd0;
      end else if (pix_acc) begin
        if (pk_cnt == 2'd3) begin
          pk_cnt  <= 2'd0;
          pk_word <= 32'd0;
        end else begin
          pk_word[{pk_cnt, 3'b000} +: 8] <= pix_data;
          pk_cnt                         <= pk_cnt + 2'd1;
        end
      end
    end
  end

  // Burst sequencer: request, transfer, then address/frame bookkeeping.
  always_ff @(posedge mem_clk0 or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state         <= IDLE;
      wr_mem_req    <= 1'b0;
      wr_mem_addr   <= BASE_ADDR;
      wr_xfr_len    <= XFR_LEN_L;
      frame_done    <= 1'b0;
      xfer_cnt      <= {XFR_LEN_W{1'b0}};
      words_written <= 32'd0;
      start_pend    <= 1'b0;
      flush_pend    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == NEXT) start_pend <= 1'b0;
      else if (state == XFER && frame_start) start_pend <= 1'b1;
      if (start_now) flush_pend <= 1'b0;
      else if (state == IDLE && flush_active && !pad_now) flush_pend <= 1'b0;
      else if (flush_active) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start_now) begin
            wr_mem_addr   <= BASE_ADDR;
            words_written <= 32'd0;
          end else if (fifo_count >= XFR_LEN_C) begin
            state      <= REQ;
            wr_mem_req <= 1'b1;
            wr_xfr_len <= XFR_LEN_L;
          end else if (flush_active && !pad_now && fifo_count != {CW{1'b0}}) begin
            state      <= REQ;
            wr_mem_req <= 1'b1;
            wr_xfr_len <= XFR_LEN_W'(fifo_count);
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (start_now) begin
            state         <= IDLE;
            wr_mem_req    <= 1'b0;
            wr_mem_addr   <= BASE_ADDR;
            words_written <= 32'd0;
          end else if (wr_mem_grant) begin
            state      <= XFER;
            wr_mem_req <= 1'b0;
            xfer_cnt   <= {XFR_LEN_W{1'b0}};
          end
        end
        XFER: begin
          if (fifo_pop) begin
            if (xfer_cnt == wr_xfr_len - XFR_LEN_W'(1)) state <= NEXT;
            else xfer_cnt <= xfer_cnt + XFR_LEN_W'(1);
          end
        end
        NEXT: begin
          state      <= IDLE;
          frame_done <= frame_wrap;
          if (start_now || frame_wrap) begin
            wr_mem_addr   <= BASE_ADDR;
            words_written <= 32'd0;
          end else begin
            wr_mem_addr   <= wr_mem_addr + words_to_cols(wr_xfr_len);
            words_written <= ww_next;
          end
        end
        default: begin
          state      <= IDLE;
          wr_mem_req <= 1'b0;
        end
      endcase
    end
  end

  pix_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MEM_DATA_W)
  ) u_fifo (
    .clk   (mem_clk0),
    .rst_n (mem_rst_n),
    .clr   (start_now),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (wr_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  pix_wr_buf_chk u_chk (
    .clk        (mem_clk0),
    .rst_n      (mem_rst_n),
    .pop_req    ((state == XFER) && wr_data_pull),
    .fifo_empty (fifo_empty),
    .grant      (wr_mem_grant),
    .in_req     (state == REQ)
  );

endmodule
